// File: rtl/axi_lite_mmio_bridge_if.sv
// AXI4-Lite bus bundle between an ARM-side master and the MIPS memory/MMIO bridge.
// Signal names follow the AXI slave port naming of the bridge.
interface axi_lite_mmio_bridge_if #(
    parameter int ADDR_WIDTH = 14
);
    logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
    logic                  S_AXI_AWVALID;
    logic                  S_AXI_AWREADY;
    logic [31:0]           S_AXI_WDATA;
    logic [3:0]            S_AXI_WSTRB;
    logic                  S_AXI_WVALID;
    logic                  S_AXI_WREADY;
    logic [1:0]            S_AXI_BRESP;
    logic                  S_AXI_BVALID;
    logic                  S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
    logic                  S_AXI_ARVALID;
    logic                  S_AXI_ARREADY;
    logic [31:0]           S_AXI_RDATA;
    logic [1:0]            S_AXI_RRESP;
    logic                  S_AXI_RVALID;
    logic                  S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/axi_lite_mmio_bridge.sv
// AXI4-Lite slave bridging ARM cores to MIPS memory and an MMIO window holding the
// MIPS reset control register and a bank of performance counters. One transaction at a time.
module axi_lite_mmio_bridge #(
    parameter int AXI_ADDR_WIDTH = 14,
    parameter int MEM_RD_LAT     = 1,
    parameter int NUM_CNT        = 8
) (
    input  logic                      S_AXI_ACLK,
    input  logic                      S_AXI_ARESET,
    axi_lite_mmio_bridge_if.slave     s_axi,
    output logic [AXI_ADDR_WIDTH-4:0] mem_addr,
    output logic [31:0]               mem_wdata,
    output logic [3:0]                mem_wstrb,
    output logic                      mem_we,
    output logic                      mem_re,
    input  logic [31:0]               mem_rdata,
    input  logic [32*NUM_CNT-1:0]     perf_cnt,
    output logic                      mips_rst
);
    localparam int         IDX_W       = AXI_ADDR_WIDTH - 3;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_BRESP, ST_RD, ST_RWAIT, ST_RRESP} state_t;

    state_t                    state_q, state_d;
    logic                      last_grant_wr_q, last_grant_wr_d;
    logic                      aw_full_q, aw_full_d;
    logic [AXI_ADDR_WIDTH-1:2] aw_addr_q, aw_addr_d;
    logic                      w_full_q, w_full_d;
    logic [31:0]               w_data_q, w_data_d;
    logic [3:0]                w_strb_q, w_strb_d;
    logic                      ar_full_q, ar_full_d;
    logic [AXI_ADDR_WIDTH-1:2] ar_addr_q, ar_addr_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic                      rvalid_q, rvalid_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [31:0]               rdata_q, rdata_d;
    logic [1:0]                wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]          mem_addr_q, mem_addr_d;
    logic [31:0]               mem_wdata_q, mem_wdata_d;
    logic [3:0]                mem_wstrb_q, mem_wstrb_d;
    logic                      mem_we_q, mem_we_d;
    logic                      mem_re_q, mem_re_d;
    logic                      mips_rst_q, mips_rst_d;

    logic             aw_mmio, ar_mmio, wr_pend, rd_pend, grant_wr;
    logic [IDX_W-1:0] aw_idx, ar_idx;
    logic [31:0]      mmio_rdata;
    logic [1:0]       mmio_rresp;
    logic             unused_addr_bits;

    assign aw_mmio  = aw_addr_q[AXI_ADDR_WIDTH-1];
    assign ar_mmio  = ar_addr_q[AXI_ADDR_WIDTH-1];
    assign aw_idx   = aw_addr_q[AXI_ADDR_WIDTH-2:2];
    assign ar_idx   = ar_addr_q[AXI_ADDR_WIDTH-2:2];
    assign wr_pend  = aw_full_q && w_full_q;
    assign rd_pend  = ar_full_q;
    // On a tie the type that did not win last time gets the bus.
    assign grant_wr = wr_pend && (!rd_pend || !last_grant_wr_q);

    assign unused_addr_bits = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    always_comb begin
        mmio_rdata = '0;
        mmio_rresp = RESP_SLVERR;
        if (ar_idx == '0) begin
            mmio_rdata = {31'b0, ~mips_rst_q};
            mmio_rresp = RESP_OKAY;
        end
        for (int k = 0; k < NUM_CNT; k++) begin
            if (ar_idx == IDX_W'(k + 1)) begin
                mmio_rdata = perf_cnt[32*k +: 32];
                mmio_rresp = RESP_OKAY;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        last_grant_wr_d = last_grant_wr_q;
        aw_full_d       = aw_full_q;
        aw_addr_d       = aw_addr_q;
        w_full_d        = w_full_q;
        w_data_d        = w_data_q;
        w_strb_d        = w_strb_q;
        ar_full_d       = ar_full_q;
        ar_addr_d       = ar_addr_q;
        bvalid_d        = bvalid_q;
        bresp_d         = bresp_q;
        rvalid_d        = rvalid_q;
        rresp_d         = rresp_q;
        rdata_d         = rdata_q;
        wait_cnt_d      = wait_cnt_q;
        mips_rst_d      = mips_rst_q;
        mem_addr_d      = '0;
        mem_wdata_d     = '0;
        mem_wstrb_d     = '0;
        mem_we_d        = 1'b0;
        mem_re_d        = 1'b0;

        if (s_axi.S_AXI_AWVALID && !aw_full_q) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_axi.S_AXI_AWADDR[AXI_ADDR_WIDTH-1:2];
        end
        if (s_axi.S_AXI_WVALID && !w_full_q) begin
            w_full_d = 1'b1;
            w_data_d = s_axi.S_AXI_WDATA;
            w_strb_d = s_axi.S_AXI_WSTRB;
        end
        if (s_axi.S_AXI_ARVALID && !ar_full_q) begin
            ar_full_d = 1'b1;
            ar_addr_d = s_axi.S_AXI_ARADDR[AXI_ADDR_WIDTH-1:2];
        end

        case (state_q)
            ST_IDLE: begin
                if (grant_wr) begin
                    state_d         = ST_WR;
                    last_grant_wr_d = 1'b1;
                    if (!aw_mmio) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = aw_idx;
                        mem_wdata_d = w_data_q;
                        mem_wstrb_d = w_strb_q;
                    end
                end else if (rd_pend) begin
                    state_d         = ST_RD;
                    last_grant_wr_d = 1'b0;
                    if (!ar_mmio) begin
                        mem_re_d   = 1'b1;
                        mem_addr_d = ar_idx;
                    end
                end
            end
            ST_WR: begin
                state_d  = ST_BRESP;
                bvalid_d = 1'b1;
                bresp_d  = RESP_OKAY;
                if (aw_mmio) begin
                    if (aw_idx != '0) begin
                        bresp_d = RESP_SLVERR;
                    end else if (w_strb_q[0]) begin
                        mips_rst_d = ~w_data_q[0];
                    end
                end
            end
            ST_BRESP: begin
                if (s_axi.S_AXI_BREADY) begin
                    state_d   = ST_IDLE;
                    bvalid_d  = 1'b0;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                end
            end
            ST_RD: begin
                if (ar_mmio) begin
                    state_d  = ST_RRESP;
                    rvalid_d = 1'b1;
                    rdata_d  = mmio_rdata;
                    rresp_d  = mmio_rresp;
                end else if (MEM_RD_LAT == 1) begin
                    state_d  = ST_RRESP;
                    rvalid_d = 1'b1;
                    rdata_d  = mem_rdata;
                    rresp_d  = RESP_OKAY;
                end else begin
                    state_d    = ST_RWAIT;
                    wait_cnt_d = 2'(MEM_RD_LAT - 2);
                end
            end
            ST_RWAIT: begin
                if (wait_cnt_q == 2'd0) begin
                    state_d  = ST_RRESP;
                    rvalid_d = 1'b1;
                    rdata_d  = mem_rdata;
                    rresp_d  = RESP_OKAY;
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
            ST_RRESP: begin
                if (s_axi.S_AXI_RREADY) begin
                    state_d   = ST_IDLE;
                    rvalid_d  = 1'b0;
                    ar_full_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q         <= ST_IDLE;
            last_grant_wr_q <= 1'b0;
            aw_full_q       <= 1'b0;
            aw_addr_q       <= '0;
            w_full_q        <= 1'b0;
            w_data_q        <= '0;
            w_strb_q        <= '0;
            ar_full_q       <= 1'b0;
            ar_addr_q       <= '0;
            bvalid_q        <= 1'b0;
            bresp_q         <= RESP_OKAY;
            rvalid_q        <= 1'b0;
            rresp_q         <= RESP_OKAY;
            rdata_q         <= '0;
            wait_cnt_q      <= '0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_wstrb_q     <= '0;
            mem_we_q        <= 1'b0;
            mem_re_q        <= 1'b0;
            mips_rst_q      <= 1'b1;
        end else begin
            state_q         <= state_d;
            last_grant_wr_q <= last_grant_wr_d;
            aw_full_q       <= aw_full_d;
            aw_addr_q       <= aw_addr_d;
            w_full_q        <= w_full_d;
            w_data_q        <= w_data_d;
            w_strb_q        <= w_strb_d;
            ar_full_q       <= ar_full_d;
            ar_addr_q       <= ar_addr_d;
            bvalid_q        <= bvalid_d;
            bresp_q         <= bresp_d;
            rvalid_q        <= rvalid_d;
            rresp_q         <= rresp_d;
            rdata_q         <= rdata_d;
            wait_cnt_q      <= wait_cnt_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wstrb_q     <= mem_wstrb_d;
            mem_we_q        <= mem_we_d;
            mem_re_q        <= mem_re_d;
            mips_rst_q      <= mips_rst_d;
        end
    end

    assign s_axi.S_AXI_AWREADY = ~aw_full_q;
    assign s_axi.S_AXI_WREADY  = ~w_full_q;
    assign s_axi.S_AXI_ARREADY = ~ar_full_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign mem_addr            = mem_addr_q;
    assign mem_wdata           = mem_wdata_q;
    assign mem_wstrb           = mem_wstrb_q;
    assign mem_we              = mem_we_q;
    assign mem_re              = mem_re_q;
    assign mips_rst            = mips_rst_q;
endmodule
